// File: rtl/display_scan_arbiter_pkg.sv
// display_scan_pkg
// Shared types and helpers for the 4-digit display scan arbiter.
//   scan_state_e  : scan FSM encoding (BLANK, DRIVE)
//   DIGITS        : number of multiplexed digits
//   digit_idx_t   : digit index, 0 = min_u ... 3 = hrs_d
//   nibble_sel()  : pick the BCD nibble of a packed 4-digit word
//   digit_onehot(): one-hot digit enable for an index
package display_scan_pkg;

    typedef enum logic [0:0] {
        SCAN_BLANK = 1'b0,
        SCAN_DRIVE = 1'b1
    } scan_state_e;

    localparam int DIGITS = 4;

    typedef logic [1:0] digit_idx_t;

    function automatic logic [3:0] nibble_sel(input logic [15:0] word, input digit_idx_t idx);
        return word[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] digit_onehot(input digit_idx_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/display_scan_arbiter_if.sv
// display_scan_arbiter_if
// Bus between the time/message sources, the scan arbiter and the seg7 path.
//   time_digits/time_dp : live time digits and decimal points (source side)
//   msg_req/msg_digits/msg_dp : message request and payload (source side)
//   msg_ack             : one-cycle capture pulse (arbiter side)
//   digit_sel/bcd/dp    : driven digit enable, value and decimal point
//   frame_done          : end-of-frame pulse
//   showing_msg         : message source owns the display
// modport master = sources/consumer side, modport slave = arbiter.
interface display_scan_arbiter_if;
    logic [15:0] time_digits;
    logic [3:0]  time_dp;
    logic        msg_req;
    logic [15:0] msg_digits;
    logic [3:0]  msg_dp;
    logic        msg_ack;
    logic [3:0]  digit_sel;
    logic [3:0]  bcd;
    logic        dp;
    logic        frame_done;
    logic        showing_msg;

    modport master (
        output time_digits, time_dp, msg_req, msg_digits, msg_dp,
        input  msg_ack, digit_sel, bcd, dp, frame_done, showing_msg
    );

    modport slave (
        input  time_digits, time_dp, msg_req, msg_digits, msg_dp,
        output msg_ack, digit_sel, bcd, dp, frame_done, showing_msg
    );
endinterface

// File: rtl/display_scan_arbiter_slot_timer.sv
// scan_slot_timer
// Loadable down-counter timing one BLANK or DRIVE slot.
//   clk, reset   : clock, async active-high reset
//   load_i       : load load_val_i this cycle (wins over counting)
//   load_val_i   : slot length in cycles
//   cnt_o        : current count
//   tc_o         : count is 1, i.e. this is the last cycle of the slot
//   idle_o       : count is 0; only true straight out of reset
module scan_slot_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o,
    output logic         idle_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign tc_o   = (cnt_q == W'(1));
    assign idle_o = (cnt_q == '0);
endmodule

// File: rtl/display_scan_arbiter.sv
// display_scan_arbiter
// Scan scheduler for the 4-digit multiplexed 7-segment display: digit
// rotation, per-digit timing, optional anti-ghosting blank slot, and
// time/message source arbitration with a req/ack handshake.
//   clk, reset : clock, async active-high reset
//   bus        : display_scan_arbiter_if.slave (see interface file)
// Build option: DISPLAY_SCAN_BLANK_EN inserts a BLANK slot before each digit;
// without it digits are driven back to back and BLANK_CYCLES is unused.
//
// state | meaning
// BLANK | all digits off for BLANK_CYCLES (only with DISPLAY_SCAN_BLANK_EN)
// DRIVE | digit idx on for TICK_DIV cycles, then idx advances
module display_scan_arbiter
    import display_scan_pkg::*;
#(
    parameter int TICK_DIV     = 32,
    parameter int BLANK_CYCLES = 4,
    parameter int MSG_FRAMES   = 250
) (
    input  logic                  clk,
    input  logic                  reset,
    display_scan_arbiter_if.slave bus
);
    localparam int SLOT_MAX = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
    localparam int SW       = $clog2(SLOT_MAX + 1);
    localparam int FW       = $clog2(MSG_FRAMES + 1);

    localparam logic [SW-1:0] TICK_LOAD   = SW'(TICK_DIV);
    localparam logic [FW-1:0] FRAMES_LOAD = FW'(MSG_FRAMES);

    digit_idx_t    idx_q, idx_d;
    logic          slot_load;
    logic [SW-1:0] slot_load_val;
    logic [SW-1:0] slot_cnt;
    logic          slot_tc, slot_idle;
    logic          drive_entry, drive_next, boundary, slot_last_d;

    logic          pending_q, pending_d;
    logic          showing_q, showing_d;
    logic [FW-1:0] frames_q, frames_d;
    logic [15:0]   latch_digits_q, latch_digits_d;
    logic [3:0]    latch_dp_q, latch_dp_d;

    logic          ack_q, ack_d;
    logic [3:0]    sel_q, sel_d;
    logic [3:0]    bcd_q, bcd_d;
    logic          dp_q, dp_d;
    logic          frame_done_q, frame_done_d;
    logic          idle;

    scan_slot_timer #(.W(SW)) u_slot_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (slot_load),
        .load_val_i (slot_load_val),
        .cnt_o      (slot_cnt),
        .tc_o       (slot_tc),
        .idle_o     (slot_idle)
    );

`ifdef DISPLAY_SCAN_BLANK_EN
    localparam logic [0:0]    ST_BLANK   = SCAN_BLANK;
    localparam logic [0:0]    ST_DRIVE   = SCAN_DRIVE;
    localparam logic [SW-1:0] BLANK_LOAD = SW'(BLANK_CYCLES);

    logic [0:0] state_q, state_d;

    // The idle timer after reset starts the first BLANK slot without
    // changing state, so digit 0 first drives BLANK_CYCLES cycles later.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        slot_load     = 1'b0;
        slot_load_val = BLANK_LOAD;
        drive_entry   = 1'b0;
        boundary      = 1'b0;
        if (slot_idle) begin
            slot_load = 1'b1;
        end else if (slot_tc) begin
            slot_load = 1'b1;
            if (state_q == ST_BLANK) begin
                state_d       = ST_DRIVE;
                slot_load_val = TICK_LOAD;
                drive_entry   = 1'b1;
            end else begin
                state_d  = ST_BLANK;
                idx_d    = idx_q + 2'd1;
                boundary = (idx_q == 2'd3);
            end
        end
        drive_next = (state_d == ST_DRIVE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BLANK;
        end else begin
            state_q <= state_d;
        end
    end
`else
    // Back-to-back digits: the frame boundary is the DRIVE entry of idx 0.
    always_comb begin
        idx_d         = idx_q;
        slot_load     = 1'b0;
        slot_load_val = TICK_LOAD;
        drive_entry   = 1'b0;
        boundary      = 1'b0;
        if (slot_idle) begin
            slot_load   = 1'b1;
            drive_entry = 1'b1;
        end else if (slot_tc) begin
            slot_load   = 1'b1;
            drive_entry = 1'b1;
            idx_d       = idx_q + 2'd1;
            boundary    = (idx_q == 2'd3);
        end
        drive_next = 1'b1;
    end
`endif

    // Count value after this edge is 1 -> next registered cycle is the last of its slot.
    assign slot_last_d = slot_load ? (slot_load_val == SW'(1)) : (slot_cnt == SW'(2));
    assign idle        = !pending_q && !showing_q;

    always_comb begin
        ack_d          = bus.msg_req && idle;
        pending_d      = pending_q;
        showing_d      = showing_q;
        frames_d       = frames_q;
        latch_digits_d = latch_digits_q;
        latch_dp_d     = latch_dp_q;
        frame_done_d   = drive_next && (idx_d == 2'd3) && slot_last_d;

        if (ack_d) begin
            pending_d      = 1'b1;
            latch_digits_d = bus.msg_digits;
            latch_dp_d     = bus.msg_dp;
        end
        if (frame_done_d && showing_q && (frames_q != '0)) begin
            frames_d = frames_q - 1'b1;
        end
        // Boundary and frame_done never share an edge, so no decrement clash.
        if (boundary) begin
            if (pending_q) begin
                pending_d = 1'b0;
                showing_d = 1'b1;
                frames_d  = FRAMES_LOAD;
            end else if (showing_q && (frames_q == '0)) begin
                showing_d = 1'b0;
            end
        end
    end

    // The latch only changes while idle, so it is stable whenever showing_d selects it.
    always_comb begin
        sel_d = drive_next ? digit_onehot(idx_d) : 4'h0;
        bcd_d = bcd_q;
        dp_d  = dp_q;
        if (!drive_next) begin
            bcd_d = 4'h0;
            dp_d  = 1'b0;
        end else if (drive_entry) begin
            if (showing_d) begin
                bcd_d = nibble_sel(latch_digits_q, idx_d);
                dp_d  = latch_dp_q[idx_d];
            end else begin
                bcd_d = nibble_sel(bus.time_digits, idx_d);
                dp_d  = bus.time_dp[idx_d];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q          <= 2'd0;
            pending_q      <= 1'b0;
            showing_q      <= 1'b0;
            frames_q       <= '0;
            latch_digits_q <= 16'h0;
            latch_dp_q     <= 4'h0;
            ack_q          <= 1'b0;
            sel_q          <= 4'h0;
            bcd_q          <= 4'h0;
            dp_q           <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            idx_q          <= idx_d;
            pending_q      <= pending_d;
            showing_q      <= showing_d;
            frames_q       <= frames_d;
            latch_digits_q <= latch_digits_d;
            latch_dp_q     <= latch_dp_d;
            ack_q          <= ack_d;
            sel_q          <= sel_d;
            bcd_q          <= bcd_d;
            dp_q           <= dp_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign bus.msg_ack     = ack_q;
    assign bus.digit_sel   = sel_q;
    assign bus.bcd         = bcd_q;
    assign bus.dp          = dp_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.showing_msg = showing_q;
endmodule

// File: doc/display_scan_arbiter.md
# display_scan_arbiter

Scan scheduler for the 4-digit multiplexed 7-segment display. It owns digit rotation and per-digit timing, with an optional anti-ghosting blank slot between digits. It also arbitrates the display between the live time source and a transient message source, such as a set-mode or alarm banner, through a req/ack handshake. It sits between the timekeeping counters and the seg7 decoder / pin inversion logic at the top level.

## Interface
Parameters:
- TICK_DIV, 32, clk cycles each digit is driven (32 ≈ 1 ms at 32768 Hz); legal range ≥1
- BLANK_CYCLES, 4, clk cycles with all digits off before each digit; legal range ≥1
- MSG_FRAMES, 250, full scan frames a granted message is shown; legal range ≥1

Ports:
- clk  in  1  system clock
- reset  in  1  reset; asynchronous, active-high
- time_digits  in  16  live time: [3:0] min_u, [7:4] min_d, [11:8] hrs_u, [15:12] hrs_d
- time_dp  in  4  live decimal points; bit i belongs to digit i
- msg_req  in  1  message request; held high until msg_ack
- msg_digits  in  16  message digits, same packing as time_digits
- msg_dp  in  4  message decimal points
- msg_ack  out  1  one-cycle pulse; message captured
- digit_sel  out  4  one-hot digit enable; 0 during blank
- bcd  out  4  digit value to the seg7 decoder
- dp  out  1  decimal point for the driven digit
- frame_done  out  1  one-cycle pulse at the end of each 4-digit frame
- showing_msg  out  1  high while the message source owns the display

## Operation
- FSM states: BLANK, DRIVE.
  - BLANK: digit_sel=0, bcd=0, dp=0, held for BLANK_CYCLES cycles, then go to DRIVE.
  - DRIVE: digit_sel=1<<idx, held for TICK_DIV cycles, then idx advances and FSM goes to BLANK.
- Digit index idx runs 0→1→2→3→0; idx0 = min_u, idx3 = hrs_d.
- Source for the next frame is chosen on entry to BLANK with idx=0. That cycle is the "frame boundary".
- bcd/dp come from the chosen source's nibble idx and dp bit idx.
  - Time data is sampled on DRIVE entry, so it is live.
  - Message data comes from the internal latch.
- Message handshake:
  - "Idle" means no message pending and none showing.
  - If msg_req=1 while idle: latch msg_digits/msg_dp, pulse msg_ack for 1 cycle, set pending.
  - If msg_req=1 while not idle: no ack. The requester keeps holding.
  - At the frame boundary with pending set: clear pending, set showing_msg, load frame counter = MSG_FRAMES.
  - Each frame_done while showing decrements the counter.
  - When the counter reaches 0: showing_msg clears at that frame boundary and the time source resumes.
- Frame counter width is $clog2(MSG_FRAMES+1). Slot counter width is $clog2(max(TICK_DIV,BLANK_CYCLES)+1).

## Timing
- Reset values: digit_sel=0, bcd=0, dp=0, msg_ack=0, frame_done=0, showing_msg=0. State is BLANK with idx=0, slot counter 0, pending cleared, latch cleared.
- All outputs are registered. Cycle 0 is the first edge with reset low.
  - Digit 0 first drives at cycle BLANK_CYCLES.
  - Digit period is TICK_DIV+BLANK_CYCLES.
  - Frame period is 4·(TICK_DIV+BLANK_CYCLES).
- frame_done is high during the last DRIVE cycle of idx3.
- msg_ack is high the cycle after msg_req is first sampled high while idle.
- Latency from ack to showing_msg: up to one frame (the next frame boundary).
- Simultaneous events:
  - msg_req during the final frame_done of a message: no ack that cycle. Ack follows once idle; the new message starts at the next boundary after that.
- Reset mid-frame or mid-message: immediate return to reset values, pending message discarded, no ack.

## Configuration
- DISPLAY_SCAN_BLANK_EN defined: BLANK slots are present as described.
- Not defined: BLANK state is omitted and BLANK_CYCLES is ignored.
  - Digits drive back-to-back; digit period = TICK_DIV.
  - Digit 0 first drives at cycle 0.
  - Frame boundary is DRIVE entry of idx0.

## Structure
- Package display_scan_pkg holds:
  - state enum (BLANK, DRIVE)
  - DIGITS=4 constant
  - digit index typedef (2 bits)
  - nibble-select function
- One sub-module, scan_slot_timer: loadable down-counter with a terminal-count pulse. It is shared by the BLANK and DRIVE states.

## Test plan
- Reset, defaults, time_digits=16'h1259 → digit_sel sequence 0,1,2,4,8 with bcd 9,5,2,1; each digit held 32 cycles, blank 4; frame_done every 144 cycles.
- MSG_FRAMES=2, msg_req at cycle 10 → msg_ack at cycle 11; showing_msg from cycle 144; message shown 2 frames; time resumes at cycle 432.
- Second msg_req held while a message is showing → no ack until showing_msg clears, then ack; the second message shows next.
- msg_req asserted exactly on the final frame_done → ack deferred, no frame lost or duplicated.
- reset asserted mid-DRIVE of idx2 with a message pending → all outputs 0 immediately; after release, time source only, digit 0 first.
- Build without DISPLAY_SCAN_BLANK_EN → digit_sel never 0 after cycle 0; frame period 128 cycles.
